i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- Deserializes a standard Philips I2S stereo stream (external ADC, mic codec, or loopback of the on-chip I2S transmitter) into parallel left/right sample pairs.
- Runs entirely on the system clock. SCLK, LRCLK and SD_IN are treated as asynchronous data inputs, synchronized, and edge-detected.
- Delivers one stereo frame per LRCLK period over a valid/ready handshake to downstream audio logic.
- Framing matches the transmitter: 64 SCLK per frame, 32-bit slots, MSB first, one-bit delay after each LRCLK edge, sample in the top bits of the slot. LRCLK low = left, LRCLK high = right.

Parameters:
- SAMPLE_W, 16, captured bits per channel (MSB-aligned in slot).
- SLOT_W, 32, SCLK periods per channel slot; used for overlong-slot detection.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (>=2).

Ports:
- Clk  input  1  system clock; must be >= 4x SCLK frequency.
- Reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  I2S bit clock (data, not a clock net).
- LRCLK  input  1  I2S word select.
- SD_IN  input  1  I2S serial data.
- READY  input  1  consumer accepts frame when READY && VALID.
- CLR_FLAGS  input  1  one-cycle pulse clears OVERRUN and FRAME_ERR.
- L_OUT  output  SAMPLE_W  left sample, two's complement.
- R_OUT  output  SAMPLE_W  right sample, two's complement.
- VALID  output  1  frame available.
- OVERRUN  output  1  sticky: a completed frame was dropped.
- FRAME_ERR  output  1  sticky: a short or overlong slot was detected.

Behaviour:
- Reset: L_OUT=0, R_OUT=0, VALID=0, OVERRUN=0, FRAME_ERR=0. FSM goes to IDLE, bit counter = 0, left_ok = 0, all synchronizer flops = 0.
- Synchronizers: SCLK, LRCLK and SD_IN each pass through SYNC_STAGES flops.
- Edge detect: sclk_rise is a one-Clk pulse when the synced SCLK goes 0->1.
- Sampling: all decode happens only on sclk_rise. On each sclk_rise, sample synced LRCLK (lr) and SD_IN (sd), and compare lr to lr_prev, then update lr_prev. A difference is an lr_edge.
- IDLE: ignore data. On lr_edge go to SHIFT with chan=lr and cnt=0. The bit sampled on the lr_edge is the previous slot's LSB and is discarded (one-bit delay).
- SHIFT: shift sd into sreg at the LSB each sclk_rise and increment cnt. When cnt reaches SAMPLE_W:
  - chan=0: load the left hold register and set left_ok=1.
  - chan=1: if left_ok, the frame is complete; then clear left_ok.
  - Then go to PAD.
- PAD: ignore bits; cnt keeps counting, saturating at SLOT_W+1. On lr_edge go to SHIFT (chan=lr, cnt=0).
- Short slot: lr_edge in SHIFT before SAMPLE_W bits. Discard the partial word, clear left_ok, set FRAME_ERR, restart SHIFT for the new channel.
- Overlong slot: cnt exceeds SLOT_W without an lr_edge. Set FRAME_ERR once, clear left_ok, stay in PAD.
- Frame completion, in the Clk cycle after the sclk_rise that captured the right LSB:
  - If VALID=0 or READY=1 that cycle: L_OUT <= left hold, R_OUT <= sreg, VALID <= 1.
  - Otherwise: drop the new frame, keep the old outputs, set OVERRUN.
- Handshake:
  - VALID falls the cycle after READY && VALID unless a new frame loads the same cycle.
  - A simultaneous handshake and new frame loads the new frame with VALID staying 1.
  - L_OUT/R_OUT are stable while VALID=1.
- Flags: CLR_FLAGS clears OVERRUN/FRAME_ERR. A set event in the same cycle wins.
- Latency: pin edge to sclk_rise is SYNC_STAGES+1 Clk; last right bit to VALID is SYNC_STAGES+2 Clk.
- Reset mid-frame: everything returns to reset values; the next output needs a fresh LRCLK edge and a full left+right pair.

Optional Feature:
- Macro I2S_RX_PEAK_EN.
- Defined:
  - Adds output PEAK_OUT [SAMPLE_W-1:0] (reset 0) and input PEAK_CLR.
  - On each loaded frame, PEAK_OUT <= max(PEAK_OUT, |L|, |R|), with |-2^(SAMPLE_W-1)| saturating to 2^(SAMPLE_W-1)-1.
  - PEAK_CLR zeroes it; a coincident frame load applies after the clear.
- Undefined: no ports and no logic.

Decomposition:
- Package i2s_pkg holds:
  - I2S_SAMPLE_W=16 and I2S_SLOT_W=32, shared with the transmitter.
  - typedef enum rx_state_t {RX_IDLE, RX_SHIFT, RX_PAD}.
  - typedef struct stereo_t {L,R}.
- Sub-module i2s_sync_edge: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs. Instantiated for SCLK; plain sync path for LRCLK and SD_IN.

Test Plan:
- Clk 50 MHz, SCLK 3.125 MHz, one frame L=16'h8001, R=16'h7FFE, READY=1 -> VALID one cycle, L_OUT=8001, R_OUT=7FFE, no flags.
- Stream starting mid-right-slot after reset -> partial data ignored; first VALID carries the first complete L then R pair.
- READY=0 across two frames A then B -> outputs hold A, OVERRUN=1; READY pulse -> VALID drops; CLR_FLAGS -> OVERRUN=0.
- LRCLK toggles after 10 bits of left slot -> FRAME_ERR=1, no VALID for that frame; next clean frame is delivered correctly.
- Assert Reset for 3 Clk mid-right-slot -> all outputs 0 immediately; no frame until next full pair.
- With I2S_RX_PEAK_EN: frames (L=-32768,R=100) then (L=5,R=-7) -> PEAK_OUT=32767 after both; PEAK_CLR -> 0.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared I2S framing constants and types used by the receiver
//                and the on-chip transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Captured sample width and slot length shared with the transmitter
    localparam int I2S_SAMPLE_W = 16;
    localparam int I2S_SLOT_W   = 32;

    // Receiver decode states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_PAD   = 2'd2
    } rx_state_t;

    // One stereo sample pair
    typedef struct packed {
        logic [I2S_SAMPLE_W-1:0] l;
        logic [I2S_SAMPLE_W-1:0] r;
    } stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous input with
//                single-cycle rise and fall pulses derived from the synced
//                level.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the synchronizer and remember the last level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= w_level;
        end
    end

    assign rise = w_level & ~r_prev;
    assign fall = ~w_level & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receiver
//  Description : Philips I2S stereo deserializer running on the system clock.
//                SCLK/LRCLK/SD_IN are synchronized and decoded on synced SCLK
//                rising edges; completed left/right pairs are offered on a
//                valid/ready handshake with sticky overrun/frame-error flags.
//                Optional peak meter enabled by macro I2S_RX_PEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = I2S_SAMPLE_W,
    parameter int SLOT_W      = I2S_SLOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sd_in,
    input  logic                ready,
    input  logic                clr_flags,
`ifdef I2S_RX_PEAK_EN
    input  logic                peak_clr,
    output logic [SAMPLE_W-1:0] peak_out,
`endif
    output logic [SAMPLE_W-1:0] l_out,
    output logic [SAMPLE_W-1:0] r_out,
    output logic                valid,
    output logic                overrun,
    output logic                frame_err
);

    // Counter must reach SLOT_W+1 (saturation point for overlong detection)
    localparam int CNT_W = $clog2(SLOT_W + 2);

    localparam logic [1:0]       C_ST_IDLE    = RX_IDLE;
    localparam logic [1:0]       C_ST_SHIFT   = RX_SHIFT;
    localparam logic [1:0]       C_ST_PAD     = RX_PAD;
    localparam logic [CNT_W-1:0] C_CNT_SAMPLE = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] C_CNT_SLOT   = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] C_CNT_SAT    = CNT_W'(SLOT_W + 1);

    logic                   w_sclk_rise;
    logic                   w_sclk_fall_unused;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   w_lr;
    logic                   w_sd;

    logic                   r_lr_prev;
    logic [1:0]             r_state;
    logic                   r_chan;
    logic [CNT_W-1:0]       r_cnt;
    logic [SAMPLE_W-1:0]    r_sreg;
    logic [SAMPLE_W-1:0]    r_left_hold;
    logic                   r_left_ok;
    logic                   r_frame_done;

    logic [SAMPLE_W-1:0]    r_l_out;
    logic [SAMPLE_W-1:0]    r_r_out;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_lr_change;
    logic                   w_lr_edge;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [SAMPLE_W-1:0]    w_sreg_next;
    logic                   w_err_set;
    logic                   w_load;

    // SCLK needs edge detection; LRCLK and SD_IN only need the synced level
    i2s_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall_unused)
    );

    // Plain synchronizers for word select and data, same depth as SCLK path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lr_sync <= '0;
            r_sd_sync <= '0;
        end else begin
            r_lr_sync <= {r_lr_sync[SYNC_STAGES-2:0], lrclk};
            r_sd_sync <= {r_sd_sync[SYNC_STAGES-2:0], sd_in};
        end
    end

    assign w_lr        = r_lr_sync[SYNC_STAGES-1];
    assign w_sd        = r_sd_sync[SYNC_STAGES-1];
    assign w_lr_change = (w_lr != r_lr_prev);
    assign w_lr_edge   = w_sclk_rise & w_lr_change;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_sreg_next = {r_sreg[SAMPLE_W-2:0], w_sd};

    // Short slot: word select moved before a full sample was shifted in.
    // Overlong slot: the counter passes SLOT_W while still padding.
    assign w_err_set = w_sclk_rise &
                       (((r_state == C_ST_SHIFT) & w_lr_change) |
                        ((r_state == C_ST_PAD) & ~w_lr_change & (r_cnt == C_CNT_SLOT)));

    // Slot decoder: tracks word select, shifts the sample, pairs left with right
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lr_prev    <= 1'b0;
            r_state      <= C_ST_IDLE;
            r_chan       <= 1'b0;
            r_cnt        <= '0;
            r_sreg       <= '0;
            r_left_hold  <= '0;
            r_left_ok    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_sclk_rise) begin
                r_lr_prev <= w_lr;
                case (r_state)
                    C_ST_IDLE: begin
                        if (w_lr_change) begin
                            r_state <= C_ST_SHIFT;
                            r_chan  <= w_lr;
                            r_cnt   <= '0;
                        end
                    end
                    C_ST_SHIFT: begin
                        if (w_lr_change) begin
                            // Partial word is abandoned; new slot starts now
                            r_chan    <= w_lr;
                            r_cnt     <= '0;
                            r_left_ok <= 1'b0;
                        end else begin
                            r_sreg <= w_sreg_next;
                            r_cnt  <= w_cnt_inc;
                            if (w_cnt_inc == C_CNT_SAMPLE) begin
                                if (!r_chan) begin
                                    r_left_hold <= w_sreg_next;
                                    r_left_ok   <= 1'b1;
                                end else begin
                                    r_frame_done <= r_left_ok;
                                    r_left_ok    <= 1'b0;
                                end
                                r_state <= C_ST_PAD;
                            end
                        end
                    end
                    C_ST_PAD: begin
                        if (w_lr_change) begin
                            r_state <= C_ST_SHIFT;
                            r_chan  <= w_lr;
                            r_cnt   <= '0;
                        end else if (r_cnt != C_CNT_SAT) begin
                            r_cnt <= w_cnt_inc;
                            if (r_cnt == C_CNT_SLOT) begin
                                r_left_ok <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= C_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A finished frame is accepted only if the output slot is free or draining
    assign w_load = r_frame_done & (~r_valid | ready);

    // Output register and handshake; dropped frames raise the overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_out   <= '0;
            r_r_out   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_l_out <= r_left_hold;
                r_r_out <= r_sreg;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (r_frame_done && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (clr_flags) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Sticky framing error; a new error wins over a coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else if (w_err_set) begin
            r_frame_err <= 1'b1;
        end else if (clr_flags) begin
            r_frame_err <= 1'b0;
        end
    end

    assign l_out     = r_l_out;
    assign r_out     = r_r_out;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

`ifdef I2S_RX_PEAK_EN
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_abs_l;
    logic [SAMPLE_W-1:0] w_abs_r;
    logic [SAMPLE_W-1:0] w_pk_base;
    logic [SAMPLE_W-1:0] w_pk_lmax;
    logic [SAMPLE_W-1:0] w_pk_next;

    // Magnitude of a two's complement sample; most negative value clips
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] v);
        logic [SAMPLE_W-1:0] res;
        if (!v[SAMPLE_W-1]) begin
            res = v;
        end else if (v == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            res = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            res = -v;
        end
        return res;
    endfunction

    // Running maximum; a clear in the same cycle is applied before the new frame
    always_comb begin
        w_abs_l   = abs_sat(r_left_hold);
        w_abs_r   = abs_sat(r_sreg);
        w_pk_base = peak_clr ? '0 : r_peak;
        w_pk_lmax = (w_abs_l > w_pk_base) ? w_abs_l : w_pk_base;
        w_pk_next = (w_abs_r > w_pk_lmax) ? w_abs_r : w_pk_lmax;
    end

    // Peak register updates on every frame that reaches the outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_load) begin
            r_peak <= w_pk_next;
        end else if (peak_clr) begin
            r_peak <= '0;
        end
    end

    assign peak_out = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_receiver
//  Description : Directed self-checking bench for i2s_receiver. A slot-level
//                model predicts delivered frames and sticky flags; a compare
//                process checks every presented frame and output stability.
//                Peak-meter checks compile in with macro I2S_RX_PEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int SW   = 16;
    localparam int SLOT = 32;

    logic          clk;
    logic          reset;
    logic          sclk;
    logic          lrclk;
    logic          sd_in;
    logic          ready;
    logic          clr_flags;
    logic [SW-1:0] l_out;
    logic [SW-1:0] r_out;
    logic          valid;
    logic          overrun;
    logic          frame_err;
`ifdef I2S_RX_PEAK_EN
    logic          peak_clr;
    logic [SW-1:0] peak_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Slot-level model state
    stereo_t       exp_q[$];
    logic          m_lr_prev;
    logic          m_left_ok;
    logic [SW-1:0] m_left_val;
    logic          m_valid;
    logic          m_overrun;
    logic          m_frame_err;
    logic [SW-1:0] m_peak;

    // Compare-process history
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic [SW-1:0] p_l = '0;
    logic [SW-1:0] p_r = '0;
    stereo_t       cmp_e;

    i2s_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sd_in     (sd_in),
        .ready     (ready),
        .clr_flags (clr_flags),
`ifdef I2S_RX_PEAK_EN
        .peak_clr  (peak_clr),
        .peak_out  (peak_out),
`endif
        .l_out     (l_out),
        .r_out     (r_out),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    // 50 MHz system clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] mag(input logic [SW-1:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return SW'(s);
    endfunction

    // A completed left+right pair reaches the consumer unless the slot is busy
    task automatic model_frame(input logic [SW-1:0] lv, input logic [SW-1:0] rv);
        if (!m_valid || ready) begin
            exp_q.push_back(stereo_t'({lv, rv}));
            m_valid = !ready;
            if (mag(lv) > m_peak) m_peak = mag(lv);
            if (mag(rv) > m_peak) m_peak = mag(rv);
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    // A slot opened by a word-select change carries nper-1 data periods
    task automatic model_slot(input logic lr, input int nper, input logic [SW-1:0] w);
        int d;
        d = nper - 1;
        if (lr != m_lr_prev) begin
            if (d < SW) begin
                m_frame_err = 1'b1;
                m_left_ok   = 1'b0;
            end else begin
                if (!lr) begin
                    m_left_ok  = 1'b1;
                    m_left_val = w;
                end else begin
                    if (m_left_ok) model_frame(m_left_val, w);
                    m_left_ok = 1'b0;
                end
                if (d > SLOT) begin
                    m_frame_err = 1'b1;
                    m_left_ok   = 1'b0;
                end
            end
        end
        m_lr_prev = lr;
    endtask

    task automatic model_reset();
        m_lr_prev   = 1'b0;
        m_left_ok   = 1'b0;
        m_left_val  = '0;
        m_valid     = 1'b0;
        m_overrun   = 1'b0;
        m_frame_err = 1'b0;
        m_peak      = '0;
    endtask

    // One SCLK period (3.125 MHz): data changes while SCLK is low
    task automatic send_bit(input logic lr, input logic b);
        sclk  = 1'b0;
        lrclk = lr;
        sd_in = b;
        #160;
        sclk  = 1'b1;
        #160;
    endtask

    // Sample sits in periods 1..16 after the word-select change, rest zero
    task automatic send_slot(input logic lr, input int nper, input logic [SW-1:0] w, input bit mdl);
        if (mdl) model_slot(lr, nper, w);
        for (int p = 0; p < nper; p++) begin
            send_bit(lr, (p >= 1 && p <= SW) ? w[SW-p] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] lv, input logic [SW-1:0] rv);
        send_slot(1'b0, SLOT, lv, 1'b1);
        send_slot(1'b1, SLOT, rv, 1'b1);
    endtask

    task automatic do_reset();
        sclk  = 1'b0;
        lrclk = 1'b0;
        sd_in = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_l_out", 32'(l_out), 32'h0);
        chk("rst_r_out", 32'(r_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        m_overrun   = 1'b0;
        m_frame_err = 1'b0;
        @(posedge clk);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_overrun_model"}, 32'(overrun), 32'(m_overrun));
        chk({tag, "_frame_err_model"}, 32'(frame_err), 32'(m_frame_err));
    endtask

    // Every new frame must match the model; held frames must not change
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && (!p_valid || p_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(valid), 32'h0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("frame_l", 32'(l_out), 32'(cmp_e.l));
                    chk("frame_r", 32'(r_out), 32'(cmp_e.r));
                end
            end else if (valid && p_valid) begin
                chk("hold_l", 32'(l_out), 32'(p_l));
                chk("hold_r", 32'(r_out), 32'(p_r));
            end
        end
        p_valid <= valid;
        p_ready <= ready;
        p_l     <= l_out;
        p_r     <= r_out;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sclk      = 1'b0;
        lrclk     = 1'b0;
        sd_in     = 1'b0;
        ready     = 1'b1;
        clr_flags = 1'b0;
`ifdef I2S_RX_PEAK_EN
        peak_clr  = 1'b0;
`endif
        model_reset();
        do_reset();

        // Basic frame, preceded by a right slot so the left edge is seen
        send_slot(1'b1, SLOT, 16'h0000, 1'b1);
        send_frame(16'h8001, 16'h7FFE);
        settle();
        chk("t1_l", 32'(l_out), 32'h8001);
        chk("t1_r", 32'(r_out), 32'h7FFE);
        chk("t1_valid_drop", 32'(valid), 32'h0);
        chk("t1_overrun", 32'(overrun), 32'h0);
        chk("t1_frame_err", 32'(frame_err), 32'h0);

        // Minimum-length left slot and exactly SLOT_W-length right slot
        send_slot(1'b0, 17, 16'h1357, 1'b1);
        send_slot(1'b1, 33, 16'h2468, 1'b1);
        send_slot(1'b0, SLOT, 16'h0000, 1'b1);
        settle();
        chk("t1b_l", 32'(l_out), 32'h1357);
        chk("t1b_r", 32'(r_out), 32'h2468);
        chk("t1b_frame_err", 32'(frame_err), 32'h0);
        chk_flags("t1b");

        // Stream starting mid right slot after reset
        do_reset();
        send_slot(1'b1, 8, 16'hABCD, 1'b1);
        send_frame(16'h1234, 16'h5678);
        settle();
        chk("t2_l", 32'(l_out), 32'h1234);
        chk("t2_r", 32'(r_out), 32'h5678);
        chk_flags("t2");
        pulse_clr();
        chk("t2_frame_err_clr", 32'(frame_err), 32'h0);

        // Consumer stalled across two frames: second one is dropped
        ready = 1'b0;
        send_frame(16'h0A0A, 16'h0B0B);
        send_frame(16'hC0C0, 16'hD0D0);
        settle();
        chk("t3_l_hold", 32'(l_out), 32'h0A0A);
        chk("t3_r_hold", 32'(r_out), 32'h0B0B);
        chk("t3_valid", 32'(valid), 32'h1);
        chk("t3_overrun", 32'(overrun), 32'h1);
        chk_flags("t3");
        pulse_ready();
        chk("t3_valid_drop", 32'(valid), 32'h0);
        pulse_clr();
        chk("t3_overrun_clr", 32'(overrun), 32'h0);

        // Left slot cut short after 10 bits, then a clean frame
        ready = 1'b1;
        send_slot(1'b0, 11, 16'hFFFF, 1'b1);
        send_slot(1'b1, SLOT, 16'h1111, 1'b1);
        send_frame(16'h2222, 16'h3333);
        settle();
        chk("t4_frame_err", 32'(frame_err), 32'h1);
        chk("t4_l", 32'(l_out), 32'h2222);
        chk("t4_r", 32'(r_out), 32'h3333);
        chk_flags("t4");
        pulse_clr();

        // Overlong left slot: error, pair discarded, next frame clean
        send_slot(1'b0, 40, 16'h4444, 1'b1);
        send_slot(1'b1, SLOT, 16'h5555, 1'b1);
        send_frame(16'h6666, 16'h7777);
        settle();
        chk("t5_frame_err", 32'(frame_err), 32'h1);
        chk("t5_l", 32'(l_out), 32'h6666);
        chk("t5_r", 32'(r_out), 32'h7777);
        chk_flags("t5");
        pulse_clr();

        // Reset in the middle of a right slot while a frame is held
        ready = 1'b0;
        send_frame(16'h1A2B, 16'h3C4D);
        send_slot(1'b0, SLOT, 16'h5E6F, 1'b1);
        send_slot(1'b1, 8, 16'h9999, 1'b0);
        chk("t6_pre_valid", 32'(valid), 32'h1);
        do_reset();
        ready = 1'b1;
        send_slot(1'b0, SLOT, 16'hAAAA, 1'b1);
        send_slot(1'b1, SLOT, 16'hBBBB, 1'b1);
        send_frame(16'hCCCC, 16'hDDDD);
        settle();
        chk("t6_l", 32'(l_out), 32'hCCCC);
        chk("t6_r", 32'(r_out), 32'hDDDD);
        chk_flags("t6");

`ifdef I2S_RX_PEAK_EN
        // Peak meter with the most negative sample clipping to full scale
        @(posedge clk);
        #1 peak_clr = 1'b1;
        @(posedge clk);
        #1 peak_clr = 1'b0;
        m_peak = '0;
        chk("pk_clr0", 32'(peak_out), 32'h0);
        send_frame(16'h8000, 16'h0064);
        send_frame(16'h0005, 16'hFFF9);
        settle();
        chk("pk_max", 32'(peak_out), 32'h7FFF);
        chk("pk_model", 32'(peak_out), 32'(m_peak));
        @(posedge clk);
        #1 peak_clr = 1'b1;
        @(posedge clk);
        #1 peak_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("pk_clr", 32'(peak_out), 32'h0);
`endif

        repeat (10) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
